noc_port_arbiter: RTL and testbench

- Round-robin, packet-locking (wormhole) arbiter that shares one router output link among N input async FIFOs.
- Sits entirely in the FIFO read-clock domain. Watches each FIFO's rempty/rdata, pops with rinc, and forwards flits through a single registered output stage with valid/ready.
- Once a head flit wins, the grant is held until that packet's tail flit is transferred.

---
 rtl/noc_port_arbiter_if.sv | 28 ++
 rtl/noc_port_arbiter.sv | 127 ++++++++++++
 tb/tb_noc_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_port_arbiter_if.sv
// Bundle for the arbiter's FIFO-read side and its registered output link.
// master = arbiter side, slave = the FIFOs / downstream consumer.
interface noc_port_arbiter_if #(
    parameter int unsigned N_IN = 4,
    parameter int unsigned DW   = 64,
    parameter int unsigned CW   = 16
) ();
    logic [N_IN-1:0]    rempty;
    logic [N_IN*DW-1:0] rdata;
    logic [N_IN-1:0]    rinc;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic               out_ready;
    logic [N_IN-1:0]    grant;
    logic               busy;
    logic [CW-1:0]      pkt_cnt;
    logic [CW-1:0]      err_cnt;

    modport master (
        input  rempty, rdata, out_ready,
        output rinc, out_valid, out_data, grant, busy, pkt_cnt, err_cnt
    );

    modport slave (
        output rempty, rdata, out_ready,
        input  rinc, out_valid, out_data, grant, busy, pkt_cnt, err_cnt
    );
endinterface

// File: rtl/noc_port_arbiter.sv
// Round-robin wormhole arbiter: N_IN FWFT FIFOs share one registered output link.
// A head flit locks its FIFO until the matching tail has been loaded.
module noc_port_arbiter #(
    parameter int unsigned N_IN = 4,
    parameter int unsigned DW   = 64,
    parameter int unsigned CW   = 16
) (
    input  logic                rclk,
    input  logic                rrst,
    noc_port_arbiter_if.master  bus
);
    localparam int unsigned PW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [1:0] FT_HEAD   = 2'b01;
    localparam logic [1:0] FT_TAIL   = 2'b10;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   rr_ptr, owner, win, pop_idx;
    logic            win_found, stage_free;
    logic [DW-1:0]   win_flit, own_flit, load_data;
    logic [1:0]      win_type, own_type;
    logic            pop, load, discard, pkt_done, lock;

    assign stage_free = !bus.out_valid || bus.out_ready;
    assign win_flit   = bus.rdata[32'(win)*DW +: DW];
    assign own_flit   = bus.rdata[32'(owner)*DW +: DW];
    assign win_type   = win_flit[DW-1:DW-2];
    assign own_type   = own_flit[DW-1:DW-2];

    // First non-empty FIFO after rr_ptr, wrapping modulo N_IN.
    always_comb begin
        logic [PW-1:0] cand;
        cand      = '0;
        win       = '0;
        win_found = 1'b0;
        for (int unsigned k = 1; k <= N_IN; k++) begin
            cand = PW'((32'(rr_ptr) + k) % N_IN);
            if (!win_found && !bus.rempty[cand]) begin
                win_found = 1'b1;
                win       = cand;
            end
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (lock)     state_nx = LOCKED;
            LOCKED:  if (pkt_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Misrouted body/tail flits in IDLE are dropped even when the stage is full.
    always_comb begin
        pop       = 1'b0;
        load      = 1'b0;
        discard   = 1'b0;
        pkt_done  = 1'b0;
        lock      = 1'b0;
        pop_idx   = win;
        load_data = win_flit;
        case (state)
            IDLE: begin
                if (win_found) begin
                    if (win_type == FT_HEAD || win_type == FT_SINGLE) begin
                        if (stage_free) begin
                            pop      = 1'b1;
                            load     = 1'b1;
                            lock     = (win_type == FT_HEAD);
                            pkt_done = (win_type == FT_SINGLE);
                        end
                    end else begin
                        pop     = 1'b1;
                        discard = 1'b1;
                    end
                end
            end
            LOCKED: begin
                pop_idx   = owner;
                load_data = own_flit;
                if (!bus.rempty[owner] && stage_free) begin
                    pop      = 1'b1;
                    load     = 1'b1;
                    pkt_done = (own_type == FT_TAIL);
                end
            end
            default: ;
        endcase
        bus.rinc  = (pop && !rrst) ? (N_IN'(1) << pop_idx) : '0;
        bus.grant = (state == LOCKED) ? (N_IN'(1) << owner) : '0;
        bus.busy  = (state == LOCKED);
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            rr_ptr        <= PW'(N_IN - 1);
            owner         <= '0;
            bus.pkt_cnt   <= '0;
            bus.err_cnt   <= '0;
        end else begin
            if (load) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= load_data;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (lock)
                owner <= win;
            if (pkt_done) begin
                rr_ptr      <= pop_idx;
                bus.pkt_cnt <= bus.pkt_cnt + 1'b1;
            end
            if (discard && bus.err_cnt != '1)
                bus.err_cnt <= bus.err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_noc_port_arbiter.sv
// Directed bench for noc_port_arbiter: single-cycle arbitration vectors from
// reset, then multi-cycle sequences driven through queue-modelled FWFT FIFOs.
module tb_noc_port_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned W  = 64;
    localparam logic [1:0] H = 2'b01, B = 2'b00, T = 2'b10, S = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    always #5 clk = ~clk;

    noc_port_arbiter_if #(.N_IN(N), .DW(W), .CW(16)) bus ();
    noc_port_arbiter #(.N_IN(N), .DW(W), .CW(16)) dut (.rclk(clk), .rrst(rst), .bus(bus));

    typedef struct {
        logic [3:0]  rempty;
        logic [7:0]  types;
        logic        rdy;
        logic [3:0]  rinc;
        logic        valid;
        logic [3:0]  grant;
        logic [15:0] pkt;
        logic [15:0] err;
    } vec_t;

    vec_t        tv [9];
    logic [63:0] fq [N][$];
    logic [63:0] rx[$];
    logic [63:0] ex[$];
    int          rx_cyc[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [3:0]  rinc_s, rempty_s;

    function automatic logic [63:0] flit(input logic [1:0] t, input int f, input int s);
        logic [63:0] r;
        r        = '0;
        r[63:62] = t;
        r[15:8]  = 8'(f);
        r[7:0]   = 8'(s);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.rempty[i]         = (fq[i].size() == 0);
            bus.rdata[i*W +: W]   = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
        bus.out_ready = rdy;
    endtask

    task automatic put(input int f, input logic [1:0] t, input int s);
        fq[f].push_back(flit(t, f, s));
    endtask

    // Sample at negedge, pop the FIFO models just after the rising edge.
    task automatic tick();
        @(negedge clk);
        rinc_s   = bus.rinc;
        rempty_s = bus.rempty;
        chk("rinc_legal", 64'($onehot0(rinc_s) && ((rinc_s & rempty_s) == 4'b0)), 64'd1);
        if (bus.out_valid && bus.out_ready) begin
            rx.push_back(bus.out_data);
            rx_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++)
            if (rinc_s[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        drive();
    endtask

    task automatic run_until(input int n, input int budget);
        int b;
        b = budget;
        while (rx.size() < n && b > 0) begin
            tick();
            b--;
        end
    endtask

    task automatic cmp_rx(input string nm);
        chk({nm, "_count"}, 64'(rx.size()), 64'(ex.size()));
        for (int k = 0; k < ex.size() && k < rx.size(); k++)
            chk($sformatf("%s_flit%0d", nm, k), rx[k], ex[k]);
    endtask

    task automatic reset_dut(input bit check);
        #2 rst = 1'b1;
        #1;
        if (check) begin
            chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_out_data", bus.out_data, 64'd0);
            chk("rst_rinc", 64'(bus.rinc), 64'd0);
            chk("rst_grant", 64'(bus.grant), 64'd0);
            chk("rst_busy", 64'(bus.busy), 64'd0);
            chk("rst_pkt_cnt", 64'(bus.pkt_cnt), 64'd0);
            chk("rst_err_cnt", 64'(bus.err_cnt), 64'd0);
        end
        for (int i = 0; i < N; i++) fq[i].delete();
        rdy = 1'b1;
        drive();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        rx.delete();
        rx_cyc.delete();
        ex.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] expd;
        int          w;

        // From reset rr_ptr=3, so search order is 0,1,2,3.
        tv[0] = '{4'b1111, 8'b00000000, 1'b1, 4'b0000, 1'b0, 4'b0000, 16'd0, 16'd0};
        tv[1] = '{4'b1110, 8'b00000011, 1'b1, 4'b0001, 1'b1, 4'b0000, 16'd1, 16'd0};
        tv[2] = '{4'b0111, 8'b01000000, 1'b1, 4'b1000, 1'b1, 4'b1000, 16'd0, 16'd0};
        tv[3] = '{4'b0000, 8'b01010101, 1'b1, 4'b0001, 1'b1, 4'b0001, 16'd0, 16'd0};
        tv[4] = '{4'b1001, 8'b00010000, 1'b1, 4'b0010, 1'b0, 4'b0000, 16'd0, 16'd1};
        tv[5] = '{4'b1010, 8'b00110010, 1'b1, 4'b0001, 1'b0, 4'b0000, 16'd0, 16'd1};
        tv[6] = '{4'b1011, 8'b00110000, 1'b1, 4'b0100, 1'b1, 4'b0000, 16'd1, 16'd0};
        tv[7] = '{4'b1101, 8'b00000100, 1'b0, 4'b0010, 1'b1, 4'b0010, 16'd0, 16'd0};
        tv[8] = '{4'b0110, 8'b11000010, 1'b0, 4'b0001, 1'b0, 4'b0000, 16'd0, 16'd1};

        drive();
        @(posedge clk);
        #1;
        reset_dut(1'b1);

        for (int v = 0; v < 9; v++) begin
            reset_dut(1'b0);
            rdy = tv[v].rdy;
            for (int i = 0; i < N; i++)
                if (!tv[v].rempty[i]) put(i, tv[v].types[2*i +: 2], 0);
            drive();
            tick();
            chk($sformatf("v%0d_rinc", v), 64'(rinc_s), 64'(tv[v].rinc));
            w = 0;
            for (int i = 0; i < N; i++) if (tv[v].rinc[i]) w = i;
            expd = tv[v].valid ? flit(tv[v].types[2*w +: 2], w, 0) : 64'd0;
            chk($sformatf("v%0d_out_valid", v), 64'(bus.out_valid), 64'(tv[v].valid));
            chk($sformatf("v%0d_out_data", v), bus.out_data, expd);
            chk($sformatf("v%0d_grant", v), 64'(bus.grant), 64'(tv[v].grant));
            chk($sformatf("v%0d_busy", v), 64'(bus.busy), 64'(tv[v].grant != 4'b0));
            chk($sformatf("v%0d_pkt_cnt", v), 64'(bus.pkt_cnt), 64'(tv[v].pkt));
            chk($sformatf("v%0d_err_cnt", v), 64'(bus.err_cnt), 64'(tv[v].err));
        end

        // Fairness: 3 singles per FIFO, expect strict 0,1,2,3 rotation, no bubbles.
        reset_dut(1'b0);
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < N; i++) begin
                put(i, S, s);
                ex.push_back(flit(S, i, s));
            end
        drive();
        run_until(12, 40);
        cmp_rx("fair");
        for (int k = 1; k < rx_cyc.size(); k++)
            chk($sformatf("fair_nobubble%0d", k), 64'(rx_cyc[k] - rx_cyc[0]), 64'(k));
        chk("fair_pkt_cnt", 64'(bus.pkt_cnt), 64'd12);

        // Reset mid-packet: FIFO1 locked, then async reset; FIFO2 served afterwards.
        put(1, H, 0); put(1, B, 1); put(1, B, 2); put(1, T, 3);
        drive();
        tick();
        tick();
        chk("midrst_pre_grant", 64'(bus.grant), 64'b0010);
        reset_dut(1'b1);
        put(2, H, 0); put(2, T, 1);
        ex.push_back(flit(H, 2, 0)); ex.push_back(flit(T, 2, 1));
        drive();
        tick();
        chk("midrst_grant2", 64'(bus.grant), 64'b0100);
        run_until(2, 10);
        cmp_rx("midrst");
        chk("midrst_pkt_cnt", 64'(bus.pkt_cnt), 64'd1);

        // Locking: FIFO0 packet must stay contiguous ahead of FIFO1 single.
        reset_dut(1'b0);
        put(0, H, 0); put(0, B, 1); put(0, B, 2); put(0, T, 3); put(1, S, 0);
        for (int s = 0; s < 4; s++) ex.push_back(flit(s == 0 ? H : (s == 3 ? T : B), 0, s));
        ex.push_back(flit(S, 1, 0));
        drive();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("lock_grant%0d", k), 64'(bus.grant), 64'b0001);
        end
        tick();
        chk("lock_release", 64'(bus.grant), 64'b0000);
        run_until(5, 10);
        cmp_rx("lock");
        chk("lock_pkt_cnt", 64'(bus.pkt_cnt), 64'd2);

        // Backpressure: hold out_ready low 5 cycles with body flit 2 on the link.
        reset_dut(1'b0);
        put(0, H, 0); put(0, B, 1); put(0, B, 2); put(0, B, 3); put(0, T, 4);
        for (int s = 0; s < 5; s++) ex.push_back(flit(s == 0 ? H : (s == 4 ? T : B), 0, s));
        drive();
        run_until(2, 10);
        rdy = 1'b0;
        drive();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("bp_rinc%0d", k), 64'(rinc_s), 64'd0);
            chk($sformatf("bp_hold%0d", k), bus.out_data, flit(B, 0, 2));
            chk($sformatf("bp_valid%0d", k), 64'(bus.out_valid), 64'd1);
        end
        rdy = 1'b1;
        drive();
        run_until(5, 10);
        repeat (3) tick();
        cmp_rx("bp");

        // Owner starvation: FIFO2 locked and empty while FIFO3 waits.
        reset_dut(1'b0);
        put(2, H, 0); put(2, B, 1); put(3, S, 0); put(3, S, 1);
        ex.push_back(flit(H, 2, 0)); ex.push_back(flit(B, 2, 1)); ex.push_back(flit(T, 2, 2));
        ex.push_back(flit(S, 3, 0)); ex.push_back(flit(S, 3, 1));
        drive();
        for (int b = 0; b < 10 && fq[2].size() > 0; b++) tick();
        chk("starve_drained", 64'(fq[2].size()), 64'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("starve_rinc3_%0d", k), 64'(rinc_s[3]), 64'd0);
            chk($sformatf("starve_busy%0d", k), 64'(bus.busy), 64'd1);
        end
        put(2, T, 2);
        drive();
        run_until(5, 20);
        cmp_rx("starve");
        chk("starve_pkt_cnt", 64'(bus.pkt_cnt), 64'd3);

        // Protocol error: stray body at FIFO1 head is dropped, then a packet follows.
        reset_dut(1'b0);
        put(1, B, 0); put(1, H, 1); put(1, T, 2);
        ex.push_back(flit(H, 1, 1)); ex.push_back(flit(T, 1, 2));
        drive();
        run_until(2, 10);
        cmp_rx("proto");
        chk("proto_err_cnt", 64'(bus.err_cnt), 64'd1);
        chk("proto_pkt_cnt", 64'(bus.pkt_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
